// File: rtl/multi_sync_debounce.sv
// ---------------------------------------------------------------------------
// multi_sync_debounce
//   Multi-channel synchroniser + debounce filter for asynchronous level
//   inputs (buttons, switches, flags from foreign clock domains). Each
//   channel passes through an N-flop metastability chain. It then passes a
//   counter filter that only accepts a new level after DEBOUNCE_CYCLES
//   consecutive cycles of disagreement with the current output. Registered
//   single-cycle rise/fall pulses mark every accepted change.
//
// Ports
//   dst_clk     in   1      destination clock, rising edge
//   rstn        in   1      asynchronous active-low reset
//   async_in    in   WIDTH  asynchronous level inputs
//   sync_out    out  WIDTH  synchronised, debounced levels
//   rise_pulse  out  WIDTH  one-cycle pulse when sync_out[i] goes 0->1
//   fall_pulse  out  WIDTH  one-cycle pulse when sync_out[i] goes 1->0
//   changed     out  1      OR of all pulse bits, registered with them
// ---------------------------------------------------------------------------
module multi_sync_debounce #(
  parameter int               WIDTH           = 4,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             dst_clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("multi_sync_debounce: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    $error("multi_sync_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  // -------------------------------------------------------------------------
  // Metastability chain: flop-to-flop only, no logic between stages, so the
  // placer can keep each chain tightly packed.
  // -------------------------------------------------------------------------
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic [WIDTH-1:0] synced;

  // NOTE: this array is a handful of flops, not a RAM, so resetting every
  // entry is cheap and keeps the chain from holding stale levels after reset.
  always_ff @(posedge dst_clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < SYNC_STAGES; s++) chain[s] <= RESET_VAL;
    end else begin
      chain[0] <= async_in;
      for (int s = 1; s < SYNC_STAGES; s++) chain[s] <= chain[s-1];
    end
  end

  assign synced = chain[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Debounce filter. A channel's counter runs only while synced disagrees
  // with sync_out; a single agreeing cycle clears it, so only an unbroken
  // run of DEBOUNCE_CYCLES mismatches is accepted.
  // -------------------------------------------------------------------------
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] mismatch;
  logic [WIDTH-1:0] update;

  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    mismatch = synced ^ sync_out;
    update   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      update[i] = mismatch[i] && (cnt[i] == CNT_MAX);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge dst_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      sync_out   <= RESET_VAL;
      rise_pulse <= '0;
      fall_pulse <= '0;
      changed    <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!mismatch[i] || update[i]) cnt[i] <= '0;
        else                           cnt[i] <= cnt[i] + CW'(1);
      end
      // Pulses come from the same update term that moves sync_out, so they
      // are aligned with the new level and last exactly one cycle.
      sync_out   <= (sync_out & ~update) | (synced & update);
      rise_pulse <= update &  synced;
      fall_pulse <= update & ~synced;
      changed    <= |update;
    end
  end

endmodule

// File: tb/tb_multi_sync_debounce.sv
// ---------------------------------------------------------------------------
// tb_multi_sync_debounce
//   Directed bench for multi_sync_debounce (WIDTH=4, SYNC_STAGES=2,
//   DEBOUNCE_CYCLES=4). Each stimulus that should produce an accepted change
//   pushes the expected new level and the edge number on which it must
//   appear into a scoreboard queue. Every cycle the outputs are sampled on
//   the falling clock edge. When the head entry's edge is reached it is
//   popped and its values are expected; every other cycle expects a steady
//   level and no pulses. A second instance with RESET_VAL=4'hA checks the
//   non-zero reset value.
// ---------------------------------------------------------------------------
module tb_multi_sync_debounce;

  logic       dst_clk = 1'b0;
  logic       rstn;
  logic [3:0] async_in;
  logic [3:0] sync_out, rise_pulse, fall_pulse;
  logic       changed;

  logic       rstn_a;
  logic [3:0] async_in_a;
  logic [3:0] sync_out_a, rise_pulse_a, fall_pulse_a;
  logic       changed_a;

  multi_sync_debounce #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(4'h0)
  ) dut (
    .dst_clk(dst_clk), .rstn(rstn), .async_in(async_in),
    .sync_out(sync_out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .changed(changed)
  );

  multi_sync_debounce #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(4'hA)
  ) dut_a (
    .dst_clk(dst_clk), .rstn(rstn_a), .async_in(async_in_a),
    .sync_out(sync_out_a), .rise_pulse(rise_pulse_a),
    .fall_pulse(fall_pulse_a), .changed(changed_a)
  );

  always #5 dst_clk = ~dst_clk;

  int edge_cnt = 0;
  always @(posedge dst_clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         edge_no;
    logic [3:0] sync;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       chg;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] sched_sync = 4'h0;  // level after the last scheduled change
  logic [3:0] cur_sync   = 4'h0;  // level expected on sync_out right now
  int         n_assert   = 0;
  int         n_fail     = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Schedule an accepted change: pulses follow from old/new level.
  task automatic expect_change(input string tag, input int at_edge,
                               input logic [3:0] new_sync);
    exp_t e;
    e.edge_no  = at_edge;
    e.sync     = new_sync;
    e.rise     = new_sync & ~sched_sync;
    e.fall     = ~new_sync & sched_sync;
    e.chg      = |(e.rise | e.fall);
    e.tag      = tag;
    sched_sync = new_sync;
    sb.push_back(e);
  endtask

  task automatic check_outputs();
    exp_t       e;
    logic [3:0] er = 4'h0;
    logic [3:0] ef = 4'h0;
    logic       ec = 1'b0;
    string      t  = "steady";
    if (sb.size() > 0 && sb[0].edge_no == edge_cnt) begin
      e        = sb.pop_front();
      cur_sync = e.sync;
      er       = e.rise;
      ef       = e.fall;
      ec       = e.chg;
      t        = e.tag;
    end
    check({t, "_sync"},    32'(sync_out),   32'(cur_sync));
    check({t, "_rise"},    32'(rise_pulse), 32'(er));
    check({t, "_fall"},    32'(fall_pulse), 32'(ef));
    check({t, "_changed"}, 32'(changed),    32'(ec));
    check("rv_a_sync",    32'(sync_out_a),   32'(4'hA));
    check("rv_a_pulses",  32'({rise_pulse_a, fall_pulse_a}), 32'(8'h00));
    check("rv_a_changed", 32'(changed_a),    32'(1'b0));
  endtask

  task automatic cycle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge dst_clk);
      @(negedge dst_clk);
      check_outputs();
    end
  endtask

  initial begin
    int k;
    rstn       = 1'b1;
    rstn_a     = 1'b1;
    async_in   = 4'hF;
    async_in_a = 4'hA;

    // 1: asynchronous reset with all inputs high, then release with 0.
    #2;
    rstn   = 1'b0;
    rstn_a = 1'b0;
    #1;
    check("reset_sync",    32'(sync_out), 32'(4'h0));
    check("reset_pulses",  32'({rise_pulse, fall_pulse}), 32'(8'h00));
    check("reset_changed", 32'(changed), 32'(1'b0));
    cycle(3);
    async_in = 4'h0;
    rstn     = 1'b1;
    rstn_a   = 1'b1;
    cycle(20);

    // 2: single rise on channel 0, accepted on edge 6 after capture.
    k           = edge_cnt;
    async_in[0] = 1'b1;
    expect_change("s2_rise", k + 6, 4'b0001);
    cycle(10);

    // 3: 3-cycle glitch on channel 1 must be rejected.
    async_in[1] = 1'b1;
    cycle(3);
    async_in[1] = 1'b0;
    cycle(8);
    check("s3_cnt_cleared", 32'(dut.cnt[1]), 32'(0));

    // 4: channel 2 bounces 1,0,1,0,1 then holds 1: one rise only.
    async_in[2] = 1'b1; cycle(1);
    async_in[2] = 1'b0; cycle(1);
    async_in[2] = 1'b1; cycle(1);
    async_in[2] = 1'b0; cycle(1);
    k           = edge_cnt;
    async_in[2] = 1'b1;
    expect_change("s4_settle", k + 6, 4'b0101);
    cycle(10);

    // 5: get to 4'b1000, then swap channels 2 and 3 in the same cycle.
    k        = edge_cnt;
    async_in = 4'b1000;
    expect_change("s5_setup", k + 6, 4'b1000);
    cycle(10);
    k        = edge_cnt;
    async_in = 4'b0100;
    expect_change("s5_swap", k + 6, 4'b0100);
    cycle(10);

    // 6: reset mid-count on a channel-0 rise. Channel 2 stays high, so
    // after release both channels are genuine changes from the reset value.
    async_in[0] = 1'b1;
    cycle(4);
    #1;
    rstn = 1'b0;
    #1;
    check("s6_async_sync",    32'(sync_out), 32'(4'h0));
    check("s6_async_pulses",  32'({rise_pulse, fall_pulse}), 32'(8'h00));
    check("s6_async_changed", 32'(changed), 32'(1'b0));
    cur_sync   = 4'h0;
    sched_sync = 4'h0;
    cycle(2);
    k    = edge_cnt;
    rstn = 1'b1;
    expect_change("s6_after_reset", k + 6, 4'b0101);
    cycle(12);

    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
